// File: rtl/tlp_tx_pkg.sv
// -----------------------------------------------------------------------------
// tlp_tx_pkg
// Shared definitions for the TLP transmit arbiter:
//   - requester index encoding (rw, rr, cc), also the bit positions in arb_grant
//   - arbiter FSM state and round-robin pointer types
//   - default widths and the completion burst limit
//   - helper that turns a requester index into a one-hot grant vector
// -----------------------------------------------------------------------------
package tlp_tx_pkg;

    // Requester indices; bit i of arb_grant belongs to requester i.
    localparam int SRC_RW  = 0;
    localparam int SRC_RR  = 1;
    localparam int SRC_CC  = 2;
    localparam int NUM_SRC = 3;

    // Default widths.
    localparam int DEF_AXI_DATA_WIDTH = 128;
    localparam int DEF_USER_WIDTH_TX  = 4;
    localparam int DEF_CC_MAX_BURST   = 4;

    // Completion burst counter width; CC_MAX_BURST is limited to 1..15.
    localparam int CC_CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Which of rw/rr goes first when both are pending.
    typedef enum logic {
        PTR_RW = 1'b0,
        PTR_RR = 1'b1
    } rr_ptr_e;

    function automatic logic [NUM_SRC-1:0] src_onehot(input int src);
        logic [NUM_SRC-1:0] oh;
        oh      = '0;
        oh[src] = 1'b1;
        return oh;
    endfunction

endpackage : tlp_tx_pkg

// File: rtl/axis_reg_slice.sv
// -----------------------------------------------------------------------------
// axis_reg_slice
// Single-stage AXI-Stream forward register. The payload (data, strb, last,
// user) and valid are registered; ready towards the source is
// ~valid_q | m_ready_i, so the stage sustains one beat per cycle and the only
// combinational path to s_ready_o comes from m_ready_i and registered state.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   s_data_i .. s_user_i   incoming beat payload
//   s_valid_i / s_ready_o  incoming handshake
//   m_data_o .. m_user_o   registered beat payload
//   m_valid_o / m_ready_i  outgoing handshake
// -----------------------------------------------------------------------------
module axis_reg_slice #(
    parameter int DATA_W = 128,
    parameter int STRB_W = DATA_W / 8,
    parameter int USER_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic [DATA_W-1:0] s_data_i,
    input  logic [STRB_W-1:0] s_strb_i,
    input  logic              s_last_i,
    input  logic [USER_W-1:0] s_user_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,

    output logic [DATA_W-1:0] m_data_o,
    output logic [STRB_W-1:0] m_strb_o,
    output logic              m_last_o,
    output logic [USER_W-1:0] m_user_o,
    output logic              m_valid_o,
    input  logic              m_ready_i
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [STRB_W-1:0] strb_q;
    logic              last_q;
    logic [USER_W-1:0] user_q;
    logic              load;

    // The register can take a new beat when empty or when its beat leaves now.
    assign s_ready_o = ~valid_q | m_ready_i;
    assign load      = s_valid_i & s_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the payload registers are reset as well because the merged stream
    // must present all-zero data/strb/user/last while in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= s_data_i;
            strb_q  <= s_strb_i;
            last_q  <= s_last_i;
            user_q  <= s_user_i;
        end else if (m_ready_i) begin
            // Beat consumed and nothing new arrived: the stage empties.
            // Payload is left as is; it is only meaningful under valid.
            valid_q <= 1'b0;
        end
    end

    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;
    assign m_strb_o  = strb_q;
    assign m_last_o  = last_q;
    assign m_user_o  = user_q;

endmodule : axis_reg_slice

// File: rtl/tlp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tlp_tx_arbiter
// Packet-granular arbiter merging three AXIS TLP requesters onto one transmit
// stream in the axi_clk domain:
//   rw  DMA write requests
//   rr  DMA read requests
//   cc  host-read completions
// Completions win by default, but after CC_MAX_BURST consecutive cc packets
// with rw/rr waiting, one rw/rr packet is forced through. rw and rr share the
// remaining slots round-robin. A grant is held for a whole packet; after the
// tlast handshake the arbiter spends one cycle in IDLE before re-arbitrating.
// The merged stream leaves through a registered slice (axis_reg_slice).
//
// Ports:
//   axi_clk, axi_rst_n        clock, asynchronous active-low reset
//   s_axis_{rw,rr,cc}_*       requester streams (tdata/tstrb/tlast/tvalid/
//                             tuser in, tready out)
//   m_axis_tx_*               merged stream (tready in, the rest out)
//   arb_grant                 one-hot current owner {cc,rr,rw}, 0 when idle
// -----------------------------------------------------------------------------
module tlp_tx_arbiter
    import tlp_tx_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
    parameter int BE_WIDTH       = AXI_DATA_WIDTH / 8,
    parameter int USER_WIDTH_TX  = DEF_USER_WIDTH_TX,
    parameter int CC_MAX_BURST   = DEF_CC_MAX_BURST
) (
    input  logic                      axi_clk,
    input  logic                      axi_rst_n,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_rw_tdata,
    input  logic [BE_WIDTH-1:0]       s_axis_rw_tstrb,
    input  logic                      s_axis_rw_tlast,
    input  logic                      s_axis_rw_tvalid,
    input  logic [USER_WIDTH_TX-1:0]  s_axis_rw_tuser,
    output logic                      s_axis_rw_tready,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_rr_tdata,
    input  logic [BE_WIDTH-1:0]       s_axis_rr_tstrb,
    input  logic                      s_axis_rr_tlast,
    input  logic                      s_axis_rr_tvalid,
    input  logic [USER_WIDTH_TX-1:0]  s_axis_rr_tuser,
    output logic                      s_axis_rr_tready,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_cc_tdata,
    input  logic [BE_WIDTH-1:0]       s_axis_cc_tstrb,
    input  logic                      s_axis_cc_tlast,
    input  logic                      s_axis_cc_tvalid,
    input  logic [USER_WIDTH_TX-1:0]  s_axis_cc_tuser,
    output logic                      s_axis_cc_tready,

    output logic [AXI_DATA_WIDTH-1:0] m_axis_tx_tdata,
    output logic [BE_WIDTH-1:0]       m_axis_tx_tstrb,
    output logic                      m_axis_tx_tlast,
    output logic                      m_axis_tx_tvalid,
    output logic [USER_WIDTH_TX-1:0]  m_axis_tx_tuser,
    input  logic                      m_axis_tx_tready,

    output logic [2:0]                arb_grant
);

    // -------------------------------------------------------------------------
    // Gather the requesters into index-addressable vectors.
    // -------------------------------------------------------------------------
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_last;
    logic [AXI_DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [BE_WIDTH-1:0]       src_strb [NUM_SRC];
    logic [USER_WIDTH_TX-1:0]  src_user [NUM_SRC];

    assign src_valid[SRC_RW] = s_axis_rw_tvalid;
    assign src_valid[SRC_RR] = s_axis_rr_tvalid;
    assign src_valid[SRC_CC] = s_axis_cc_tvalid;
    assign src_last[SRC_RW]  = s_axis_rw_tlast;
    assign src_last[SRC_RR]  = s_axis_rr_tlast;
    assign src_last[SRC_CC]  = s_axis_cc_tlast;
    assign src_data[SRC_RW]  = s_axis_rw_tdata;
    assign src_data[SRC_RR]  = s_axis_rr_tdata;
    assign src_data[SRC_CC]  = s_axis_cc_tdata;
    assign src_strb[SRC_RW]  = s_axis_rw_tstrb;
    assign src_strb[SRC_RR]  = s_axis_rr_tstrb;
    assign src_strb[SRC_CC]  = s_axis_cc_tstrb;
    assign src_user[SRC_RW]  = s_axis_rw_tuser;
    assign src_user[SRC_RR]  = s_axis_rr_tuser;
    assign src_user[SRC_CC]  = s_axis_cc_tuser;

    // -------------------------------------------------------------------------
    // Arbitration state
    // -------------------------------------------------------------------------
    arb_state_e          state_q;
    logic [NUM_SRC-1:0]  grant_q;
    logic [NUM_SRC-1:0]  grant_d;
    rr_ptr_e             rr_ptr_q;
    rr_ptr_e             rr_ptr_d;
    logic [CC_CNT_W-1:0] cc_cnt_q;
    logic [CC_CNT_W-1:0] cc_cnt_d;

    logic rq_pending;
    logic cc_below_max;

    assign rq_pending   = src_valid[SRC_RW] | src_valid[SRC_RR];
    assign cc_below_max = (cc_cnt_q < CC_CNT_W'(CC_MAX_BURST));

    // Winner selection. Only consumed in IDLE, but evaluated every cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        grant_d = '0;
        if (src_valid[SRC_CC] && (cc_below_max || !rq_pending)) begin
            grant_d = src_onehot(SRC_CC);
        end else if (src_valid[SRC_RW] && src_valid[SRC_RR]) begin
            grant_d = (rr_ptr_q == PTR_RR) ? src_onehot(SRC_RR) : src_onehot(SRC_RW);
        end else if (src_valid[SRC_RW]) begin
            grant_d = src_onehot(SRC_RW);
        end else if (src_valid[SRC_RR]) begin
            grant_d = src_onehot(SRC_RR);
        end
    end

    // Burst counter and round-robin pointer follow the winner.
    always_comb begin
        cc_cnt_d = cc_cnt_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_d[SRC_CC]) begin
            // Saturates at CC_MAX_BURST.
            if (cc_below_max) begin
                cc_cnt_d = cc_cnt_q + CC_CNT_W'(1);
            end
        end else if (|grant_d) begin
            cc_cnt_d = '0;
            rr_ptr_d = (rr_ptr_q == PTR_RW) ? PTR_RR : PTR_RW;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath mux: the granted requester feeds the output slice. With no
    // grant (IDLE or the bubble after tlast) the slice sees no valid.
    // -------------------------------------------------------------------------
    logic                      sel_valid;
    logic                      sel_last;
    logic [AXI_DATA_WIDTH-1:0] sel_data;
    logic [BE_WIDTH-1:0]       sel_strb;
    logic [USER_WIDTH_TX-1:0]  sel_user;
    logic                      slice_ready;
    logic                      sel_hs;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        sel_user  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                sel_data  = src_data[i];
                sel_strb  = src_strb[i];
                sel_user  = src_user[i];
            end
        end
    end

    assign sel_hs = sel_valid & slice_ready;

    // tready depends only on the grant register and the slice's ready, which
    // itself is built from m_axis_tx_tready and the registered output valid.
    assign s_axis_rw_tready = grant_q[SRC_RW] & slice_ready;
    assign s_axis_rr_tready = grant_q[SRC_RR] & slice_ready;
    assign s_axis_cc_tready = grant_q[SRC_CC] & slice_ready;

    // -------------------------------------------------------------------------
    // Arbiter FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= PTR_RW;
            cc_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|src_valid) begin
                        state_q  <= XFER;
                        grant_q  <= grant_d;
                        cc_cnt_q <= cc_cnt_d;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                XFER: begin
                    // Grant is held until the owner's tlast is accepted; other
                    // requesters and gaps in the owner's tvalid are ignored.
                    if (sel_hs && sel_last) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
            endcase
        end
    end

    assign arb_grant = grant_q;

    // -------------------------------------------------------------------------
    // Output register stage
    // -------------------------------------------------------------------------
    axis_reg_slice #(
        .DATA_W (AXI_DATA_WIDTH),
        .STRB_W (BE_WIDTH),
        .USER_W (USER_WIDTH_TX)
    ) u_out_slice (
        .clk_i     (axi_clk),
        .rst_ni    (axi_rst_n),
        .s_data_i  (sel_data),
        .s_strb_i  (sel_strb),
        .s_last_i  (sel_last),
        .s_user_i  (sel_user),
        .s_valid_i (sel_valid),
        .s_ready_o (slice_ready),
        .m_data_o  (m_axis_tx_tdata),
        .m_strb_o  (m_axis_tx_tstrb),
        .m_last_o  (m_axis_tx_tlast),
        .m_user_o  (m_axis_tx_tuser),
        .m_valid_o (m_axis_tx_tvalid),
        .m_ready_i (m_axis_tx_tready)
    );

endmodule : tlp_tx_arbiter

// File: doc/tlp_tx_arbiter.md
Name: tlp_tx_arbiter

Overview:
- Packet-granular arbiter that shares one AXIS TLP transmit path between three requesters: DMA write requests (rw), DMA read requests (rr) and host-read completions (cc).
- Sits in the axi_clk domain ahead of the AXI-to-TRN/Avalon TX bridge and drives a single merged AXIS stream.
- Completions have priority, with a starvation guard. rw and rr are served round-robin.
- A registered output stage gives full throughput without combinational paths from the output to the inputs' tready.

Parameters:
- AXI_DATA_WIDTH, 128, tdata width in bits.
- BE_WIDTH, AXI_DATA_WIDTH/8, tstrb width.
- USER_WIDTH_TX, 4, tuser width.
- CC_MAX_BURST, 4, maximum consecutive cc packets while rw/rr is pending (range 1..15).

Ports:
- axi_clk  in  1  clock; all logic is rising-edge.
- axi_rst_n  in  1  asynchronous, active-low reset.
- s_axis_rw_tdata  in  AXI_DATA_WIDTH  write request data.
- s_axis_rw_tstrb  in  BE_WIDTH  write request byte strobes.
- s_axis_rw_tlast  in  1  write request end of packet.
- s_axis_rw_tvalid  in  1  write request beat valid.
- s_axis_rw_tuser  in  USER_WIDTH_TX  write request sideband.
- s_axis_rw_tready  out  1  write request accept.
- s_axis_rr_tdata/tstrb/tlast/tvalid/tuser/tready: same widths, directions and roles as rw, for read requests.
- s_axis_cc_tdata/tstrb/tlast/tvalid/tuser/tready: same widths, directions and roles as rw, for completions.
- m_axis_tx_tdata  out  AXI_DATA_WIDTH  merged data.
- m_axis_tx_tstrb  out  BE_WIDTH  merged strobes.
- m_axis_tx_tlast  out  1  merged end of packet.
- m_axis_tx_tvalid  out  1  merged beat valid.
- m_axis_tx_tuser  out  USER_WIDTH_TX  merged sideband.
- m_axis_tx_tready  in  1  downstream accept.
- arb_grant  out  3  one-hot current owner {cc,rr,rw}; 0 when idle.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all s_*_tready = 0, m_axis_tx_tvalid = 0, m_axis_tx_tlast = 0, m_data/strb/user = 0.
  - arb_grant = 0, state = IDLE, rr_ptr = rw, cc_cnt = 0.
- A handshake occurs when tvalid & tready are both high in the same cycle. A beat's payload is sampled only on a handshake.
- FSM states are IDLE and XFER.
- IDLE:
  - No tready is asserted.
  - If any s_*_tvalid is high, the arbiter selects a winner, registers arb_grant and moves to XFER on the next edge.
  - Arbitration latency is 1 cycle from IDLE to the first tready.
- Winner selection:
  - cc wins if cc_tvalid and (cc_cnt < CC_MAX_BURST, or neither rw nor rr is valid).
  - Otherwise, between valid rw/rr, rr_ptr picks: rr_ptr = rw means rw goes first; after serving one, the pointer moves to the other.
  - If only one is valid, it wins regardless of the pointer.
- Winner updates:
  - cc_cnt increments (saturating at CC_MAX_BURST) when cc wins.
  - cc_cnt clears when rw or rr wins.
  - rr_ptr toggles only when rw or rr wins.
- XFER:
  - Only the granted input's tready may be high: s_grant_tready = ~m_axis_tx_tvalid | m_axis_tx_tready. All other treadys are 0.
  - On an input handshake, the output register loads the beat and m_axis_tx_tvalid = 1 next cycle.
  - If m_axis_tx_tready = 1 with no new input handshake, m_axis_tx_tvalid clears.
  - Output register holds stable while tvalid & ~tready (AXIS rule).
- Packet end:
  - A handshake with tlast = 1 on the granted input sets state = IDLE and arb_grant = 0 on the next edge.
  - The next arbitration happens in the following cycle, giving one bubble cycle between packets.
  - The final beat still drains through the output register independently.
- Grant rules:
  - A grant never changes mid-packet; other requesters' tvalid is ignored in XFER.
  - A granted requester dropping tvalid mid-packet causes a stall, not re-arbitration.
- Single-beat packets (tlast on the first beat) are supported: XFER lasts exactly 1 handshake.
- Boundary cases:
  - Downstream backpressure holds the output register, and the input tready goes low in the same cycle (combinational from m_axis_tx_tready and the registered tvalid only).
  - All three requesters valid simultaneously with cc_cnt = 0 gives cc first.
  - Reset mid-packet abandons the partial packet: the output deasserts immediately and nothing is replayed.
  - CC_MAX_BURST packets of continuous cc while rw is pending forces one rw/rr packet, then cc resumes.

Decomposition:
- Package tlp_tx_pkg holds:
  - source encoding constants SRC_RW = 0, SRC_RR = 1, SRC_CC = 2;
  - the state enum {IDLE, XFER};
  - the default widths.
- One sub-module, axis_reg_slice: a single-stage AXIS forward register holding data, strb, last, user and valid, parameterised by width. It is instantiated for the output.

Test Plan:
- rw only, 3-beat packet, m_tready = 1 → rw_tready rises 1 cycle after rw_tvalid; 3 output beats with tlast on the 3rd; arb_grant = 001 then 000.
- rw and rr both continuously valid, 1-beat packets → output source order rw, rr, rw, rr; one idle cycle between packets.
- cc, rw and rr all valid continuously, CC_MAX_BURST = 4 → order cc ×4, rw, cc ×4, rr.
- rr 4-beat packet with m_tready toggling 1,0,0,1,… → no beat lost or duplicated; output held stable while stalled; rr_tready = 0 in stall cycles.
- cc asserts tvalid mid rw packet → cc_tready stays 0 until rw tlast is accepted; cc is granted next arbitration.
- axi_rst_n pulsed low on the 2nd beat of a 4-beat rw packet → all tready and m_axis_tx_tvalid = 0 asynchronously; after release, IDLE with arb_grant = 0 and rr_ptr = rw.
